// File: rtl/clk_div_gen.sv
// Purpose: N_CH phase-aligned integer clock dividers with runtime reconfig and lock flag.
// Latency: outputs registered; config takes effect one cycle after acceptance (APPLY edge).
// Backpressure: cfg_ready_o drops during reset and the single APPLY cycle; requester must hold.
module clk_div_gen #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int DEF_DIV     = 10,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             refclk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [3:0]       cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic [CNT_W-1:0] cfg_phase_i,
  output logic             cfg_err_o,
  output logic [N_CH-1:0]  outclk_o,
  output logic [N_CH-1:0]  outclk_en_o,
  output logic             locked_o
);

  localparam int              SET_W      = $clog2(LOCK_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_DIV / 2);
  localparam logic [4:0]       N_CH_C     = 5'(N_CH);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] div_q   [N_CH];
  logic [CNT_W-1:0] div_d   [N_CH];
  logic [CNT_W-1:0] high_q  [N_CH];
  logic [CNT_W-1:0] high_d  [N_CH];
  logic [CNT_W-1:0] phase_q [N_CH];
  logic [CNT_W-1:0] phase_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W:0]   diff_w  [N_CH];
  logic [CNT_W-1:0] start_w [N_CH];

  logic [N_CH-1:0] out_q, out_d;
  logic [N_CH-1:0] en_q, en_d;

  logic cfg_fire;
  logic cfg_bad;
  logic cfg_take;

  assign cfg_ready_o = ~rst_i & (state_q != ST_APPLY);
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign cfg_bad     = ({1'b0, cfg_ch_i} >= N_CH_C) |
                       (cfg_div_i < CNT_W'(2)) |
                       (cfg_high_i == '0) |
                       (cfg_high_i >= cfg_div_i) |
                       (cfg_phase_i >= cfg_div_i);
  assign cfg_take    = cfg_fire & ~cfg_bad;

  // Lock FSM: settle count after every restart, APPLY restarts all channels together.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    locked_d = locked_q;
    err_d    = cfg_fire & cfg_bad;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_END) begin
          locked_d = 1'b1;
          state_d  = ST_LOCKED;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      ST_APPLY: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
        locked_d = 1'b0;
      end
      default: begin
        state_d = ST_SETTLE;
      end
    endcase
    if (cfg_take) begin
      state_d = ST_APPLY;
    end
  end

  // Start value per channel: (div - phase) mod div with one conditional subtract.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      diff_w[i]  = {1'b0, div_q[i]} - {1'b0, phase_q[i]};
      start_w[i] = (diff_w[i] >= {1'b0, div_q[i]}) ?
                   CNT_W'(diff_w[i] - {1'b0, div_q[i]}) : CNT_W'(diff_w[i]);
    end
  end

  // Shadow config update and per-channel counters with output decode from next count.
  always_comb begin
    out_d = '0;
    en_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      div_d[i]   = div_q[i];
      high_d[i]  = high_q[i];
      phase_d[i] = phase_q[i];
      if (cfg_take && (cfg_ch_i == 4'(i))) begin
        div_d[i]   = cfg_div_i;
        high_d[i]  = cfg_high_i;
        phase_d[i] = cfg_phase_i;
      end
      if (state_q == ST_APPLY) begin
        cnt_d[i] = start_w[i];
      end else if (cnt_q[i] >= div_q[i] - 1'b1) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      out_d[i] = (cnt_d[i] < high_q[i]);
      en_d[i]  = (cnt_d[i] == '0);
    end
  end

  // State, config and counter registers; reset restores the default divide on every channel.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
      en_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]   <= DEF_DIV_C;
        high_q[i]  <= DEF_HIGH_C;
        phase_q[i] <= '0;
        cnt_q[i]   <= DEF_DIV_C - 1'b1;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      out_q    <= out_d;
      en_q     <= en_d;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]   <= div_d[i];
        high_q[i]  <= high_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign outclk_o    = out_q;
  assign outclk_en_o = en_q;
  assign locked_o    = locked_q;
  assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: per-cycle scoreboard against a waveform-level reference model.
// Model pushes one expected output vector per clock edge; a monitor pops it on the falling edge.
// Directed scenarios follow the block's intended use, then randomized reconfiguration and resets.
module tb_clk_div_gen;
  localparam int N_CH        = 4;
  localparam int CNT_W       = 8;
  localparam int DEF_DIV     = 10;
  localparam int LOCK_CYCLES = 16;
  localparam int VW          = 2 * N_CH + 2;

  logic             refclk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;
  logic [N_CH-1:0]  outclk;
  logic [N_CH-1:0]  outclk_en;
  logic             locked;

  always #5 refclk = ~refclk;

  clk_div_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk_i(refclk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_high_i(cfg_high), .cfg_phase_i(cfg_phase),
    .cfg_err_o(cfg_err), .outclk_o(outclk), .outclk_en_o(outclk_en), .locked_o(locked)
  );

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  // Reference model: each channel is the phase-0 waveform of its active config,
  // delayed circularly; k counts edges since the last common restart.
  int sdiv [N_CH];
  int shigh[N_CH];
  int sph  [N_CH];
  int adiv [N_CH];
  int ahigh[N_CH];
  int adel [N_CH];
  int k = 0;
  bit pend = 1'b0;
  bit exp_err = 1'b0;
  logic [VW-1:0] expq[$];

  function automatic bit is_bad(input int ch, input int d, input int h, input int p);
    return (ch >= N_CH) || (d < 2) || (h == 0) || (h >= d) || (p >= d);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [VW-1:0] v;
    int pos;
    bit acc;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sdiv[i] = DEF_DIV; shigh[i] = DEF_DIV / 2; sph[i] = 0;
        adiv[i] = DEF_DIV; ahigh[i] = DEF_DIV / 2;
        adel[i] = 1;  // first edge after release shows period start
      end
      k = 0; pend = 1'b0; exp_err = 1'b0;
    end else begin
      acc = cfg_valid && !pend;
      if (pend) begin
        for (int i = 0; i < N_CH; i++) begin
          adiv[i] = sdiv[i]; ahigh[i] = shigh[i]; adel[i] = sph[i];
        end
        k = 0; pend = 1'b0;
      end else begin
        k++;
      end
      exp_err = 1'b0;
      if (acc) begin
        if (is_bad(int'(cfg_ch), int'(cfg_div), int'(cfg_high), int'(cfg_phase))) begin
          exp_err = 1'b1;
        end else begin
          sdiv[cfg_ch] = int'(cfg_div); shigh[cfg_ch] = int'(cfg_high); sph[cfg_ch] = int'(cfg_phase);
          pend = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      pos = ((k - adel[i]) % adiv[i] + adiv[i]) % adiv[i];
      v[i]        = (pos < ahigh[i]);
      v[N_CH + i] = (pos == 0);
    end
    v[2*N_CH]     = exp_err;
    v[2*N_CH + 1] = (k >= LOCK_CYCLES + 1);
    expq.push_back(v);
  endtask

  initial forever begin
    @(posedge refclk);
    model_step();
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  initial forever begin
    logic [VW-1:0] e;
    logic [VW-1:0] a;
    @(negedge refclk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {locked, cfg_err, outclk_en, outclk};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_out @%0t: got lock/err/en/clk %b expected %b", $time, a, e);
      end
      checks++;
      if (cfg_ready !== (!rst && !pend)) begin
        errors++;
        $display("FAIL cfg_ready @%0t: got %b expected %b", $time, cfg_ready, (!rst && !pend));
      end
    end
  end

  initial forever begin
    @(negedge refclk);
    if (cfg_err === 1'b1) err_seen++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic send_cfg(input int ch, input int d, input int h, input int p, output int waited);
    logic r;
    bit done;
    done = 1'b0;
    waited = 0;
    cfg_ch = 4'(ch); cfg_div = 8'(d); cfg_high = 8'(h); cfg_phase = 8'(p);
    cfg_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge refclk);
      r = cfg_ready;
      @(posedge refclk);
      #2;
      if (r === 1'b1) begin
        done = 1'b1;
        break;
      end
      waited++;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic wait_locked();
    for (int t = 0; t < 60; t++) begin
      @(negedge refclk);
      if (locked === 1'b1) break;
    end
    chk("wait_locked", int'(locked === 1'b1), 1);
    wait_cyc(1);
  endtask

  task automatic count_unlocked(input string name, input int exp);
    int cnt;
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge refclk);
      if (locked === 1'b1 && cnt > 0) break;
      if (locked !== 1'b1) cnt++;
    end
    chk(name, cnt, exp);
    wait_cyc(1);
  endtask

  initial begin
    int n, w, w2, e0, t0, t2, r, ch, d, h, p;
    logic [N_CH-1:0] prev;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;
    wait_cyc(3);
    rst = 1'b0;

    // Defaults after reset: lock on the 17th edge after release.
    n = 0;
    for (int t = 0; t <= 40; t++) begin
      @(negedge refclk);
      n = t;
      if (locked === 1'b1) break;
    end
    chk("lock_edge_after_reset", n, LOCK_CYCLES + 1);
    wait_cyc(100 - n);

    // ch1 div4 high1 phase0: locked low for 1+LOCK_CYCLES cycles.
    send_cfg(1, 4, 1, 0, w);
    chk("stall_locked_state", w, 0);
    count_unlocked("locked_low_cycles", LOCK_CYCLES + 1);
    wait_cyc(20);

    // ch2 div10 high5 phase3: rising edge lags ch0 by 3 cycles.
    send_cfg(2, 10, 5, 3, w);
    t0 = -1; t2 = -1;
    @(negedge refclk);
    prev = outclk;
    for (int t = 1; t < 40; t++) begin
      @(negedge refclk);
      if (t0 < 0 && outclk[0] && !prev[0]) t0 = t;
      else if (t0 >= 0 && outclk[2] && !prev[2]) begin t2 = t; break; end
      prev = outclk;
    end
    chk("ch2_lag_ch0", t2 - t0, 3);
    wait_cyc(1);
    wait_locked();

    // Rejected requests: one error pulse each, nothing else moves.
    e0 = err_seen;
    send_cfg(0, 1, 1, 0, w); wait_cyc(3);
    send_cfg(0, 8, 0, 0, w); wait_cyc(3);
    send_cfg(0, 8, 8, 0, w); wait_cyc(3);
    send_cfg(0, 8, 4, 8, w); wait_cyc(3);
    send_cfg(5, 8, 4, 0, w); wait_cyc(3);
    chk("err_pulses", err_seen - e0, 5);
    chk("locked_after_rejects", int'(locked === 1'b1), 1);

    // Reset while LOCKED with a request held: not accepted, defaults return.
    cfg_ch = 4'd1; cfg_div = 8'd6; cfg_high = 8'd2; cfg_phase = 8'd1;
    cfg_valid = 1'b1; rst = 1'b1;
    wait_cyc(2);
    @(negedge refclk);
    chk("ready_in_reset", int'(cfg_ready), 0);
    wait_cyc(1);
    rst = 1'b0; cfg_valid = 1'b0;
    wait_locked();
    wait_cyc(30);

    // Back-to-back requests: second stalls exactly one cycle.
    send_cfg(3, 6, 2, 1, w);
    send_cfg(0, 5, 3, 2, w2);
    chk("b2b_first_wait", w, 0);
    chk("b2b_second_stall", w2, 1);
    count_unlocked("b2b_locked_low", LOCK_CYCLES + 2);
    wait_cyc(20);

    // Randomized reconfiguration with occasional reset.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(9, 0);
      if (r == 0) begin
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
      end else begin
        ch = $urandom_range(5, 0);
        d  = $urandom_range(20, 0);
        h  = $urandom_range(d + 1, 0);
        p  = $urandom_range(d, 0);
        send_cfg(ch, d, h, p, w);
      end
      wait_cyc($urandom_range(30, 0));
    end

    wait_cyc(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
